bcd_updown_counter: RTL

Parametrised multi-digit BCD up/down counter, successor to the single-digit up/down digit counter. It counts DIGITS decimal digits as one number with digit-to-digit carry/borrow, parallel load, and a terminal-count output for chaining instances. It sits between the slow-tick enable generator and the seven-segment digit mux, and drives all displayed digits from one block.

---
 rtl/bcd_counter_pkg.sv | 14 +
 rtl/bcd_digit_cell.sv | 37 +++
 rtl/bcd_updown_counter.sv | 46 ++++
 3 files changed

// File: rtl/bcd_counter_pkg.sv
// Shared BCD digit type, digit limits and load clamp for the multi-digit up/down counter.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Load data above 9 is forced to 9 so a nibble never holds 10..15.
  function automatic bcd_digit_t bcd_clamp(input logic [3:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit: register, load clamp, increment/decrement with 9<->0 wrap, and the
// carry/borrow (step) passed on to the next more-significant digit.
module bcd_digit_cell
  import bcd_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step_in,
  input  logic       up_down,
  input  logic       load,
  input  logic       hold,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output logic       step_out
);

  bcd_digit_t digit_q, digit_d;

  assign digit    = digit_q;
  assign step_out = step_in & (up_down ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN));

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(load_digit);
    end else if (step_in && !hold) begin
      if (up_down) digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      else         digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) digit_q <= BCD_MIN;
    else      digit_q <= digit_d;
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// DIGITS-wide BCD up/down counter with parallel load and cascadable terminal count.
// Define BCD_COUNTER_SATURATE_EN to saturate at 9..9 / 0..0 instead of wrapping.
module bcd_updown_counter
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                up_down,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] digits,
  output logic                tc
);

  logic [DIGITS:0] step;
  logic            sat_hold;

  assign step[0] = enable & ~load;
  assign tc      = step[DIGITS];

`ifdef BCD_COUNTER_SATURATE_EN
  // A step reaching past the MSD means every digit is at its limit: freeze them all,
  // while tc still fires so a cascaded stage keeps counting.
  assign sat_hold = step[DIGITS];
`else
  assign sat_hold = 1'b0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .step_in    (step[i]),
      .up_down    (up_down),
      .load       (load),
      .hold       (sat_hold),
      .load_digit (load_value[4*i +: 4]),
      .digit      (digits[4*i +: 4]),
      .step_out   (step[i+1])
    );
  end

endmodule
